// File: rtl/dflow_replay_engine.sv
// rtl/dflow_replay_engine.sv - credit-limited QDR window replay into a valid/ready record stream
module dflow_replay_engine #(
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int MEM_DATA_WIDTH     = 144,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int RET_DEPTH          = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cal_done,
    input  logic                          start_replay,
    input  logic                          stop_replay,
    input  logic [MEM_ADDR_WIDTH-1:0]     addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]     addr_high,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    output logic                          app_rd_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]     app_rd_addr,
    input  logic                          app_rd_valid,
    input  logic [MEM_DATA_WIDTH-1:0]     app_rd_data,
    output logic [MEM_DATA_WIDTH-1:0]     out_data,
    output logic                          out_vld,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic                          overflow,
    output logic [REPLAY_COUNT_WIDTH-1:0] passes_done,
    output logic [31:0]                   records_sent
);
    localparam int PW = $clog2(RET_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                          r_state, w_next;
    logic [MEM_ADDR_WIDTH-1:0]       r_low, r_high, r_cur, r_addr;
    logic [REPLAY_COUNT_WIDTH-1:0]   r_count, r_passes;
    logic [CW-1:0]                   r_outst, r_occ;
    logic [PW-1:0]                   r_wptr, r_rptr;
    logic [MEM_DATA_WIDTH-1:0]       r_mem [RET_DEPTH];
    logic [31:0]                     r_recs;
    logic                            r_cmd, r_cfg_err, r_ovf;

    logic                            w_start, w_start_ok, w_start_bad, w_credit, w_issue;
    logic                            w_pass_end, w_last, w_ret, w_pop, w_full, w_push, w_drop;
    logic [MEM_ADDR_WIDTH-1:0]       w_cur, w_low_sel, w_high_sel;
    logic [REPLAY_COUNT_WIDTH-1:0]   w_count_sel, w_passes_base, w_passes_next;
    logic [CW:0]                     w_credit_sum;

    // The first read issues in the same cycle the start is accepted, so the
    // pass bookkeeping works off either the live inputs or the latched config.
    always_comb begin
        w_start       = start_replay && cal_done && (r_state == IDLE);
        w_start_ok    = w_start && (addr_high >= addr_low);
        w_start_bad   = w_start && (addr_high < addr_low);
        w_credit_sum  = {1'b0, r_outst} + {1'b0, r_occ};
        w_credit      = w_credit_sum < (CW+1)'(RET_DEPTH);
        w_issue       = w_start_ok || ((r_state == ISSUE) && !stop_replay && w_credit);
        w_cur         = w_start_ok ? addr_low     : r_cur;
        w_low_sel     = w_start_ok ? addr_low     : r_low;
        w_high_sel    = w_start_ok ? addr_high    : r_high;
        w_count_sel   = w_start_ok ? replay_count : r_count;
        w_pass_end    = w_issue && (w_cur == w_high_sel);
        w_passes_base = w_start_ok ? '0 : r_passes;
        w_passes_next = (w_pass_end && (w_passes_base != '1)) ?
                        w_passes_base + REPLAY_COUNT_WIDTH'(1) : w_passes_base;
        w_last        = w_pass_end && (w_count_sel != '0) && (w_passes_next == w_count_sel);
        // Returns with nothing outstanding (e.g. stale reads after a reset) are dropped.
        w_ret         = app_rd_valid && (r_outst != '0);
        w_pop         = (r_occ != '0) && out_ready;
        w_full        = r_occ == CW'(RET_DEPTH);
        w_push        = w_ret && (!w_full || w_pop);
        w_drop        = w_ret && w_full && !w_pop;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = w_last ? DRAIN : ISSUE;
            ISSUE:   if (stop_replay || w_last) w_next = DRAIN;
            DRAIN:   if ((r_outst == '0) && (r_occ == '0)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_low     <= '0;
            r_high    <= '0;
            r_cur     <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_passes  <= '0;
            r_outst   <= '0;
            r_occ     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_recs    <= '0;
            r_cmd     <= 1'b0;
            r_cfg_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cmd     <= w_issue;
            r_cfg_err <= w_start_bad;
            if (w_start_ok) begin
                r_low   <= addr_low;
                r_high  <= addr_high;
                r_count <= replay_count;
            end
            if (w_issue) begin
                r_addr <= w_cur;
                r_cur  <= w_pass_end ? w_low_sel : w_cur + MEM_ADDR_WIDTH'(1);
            end
            if (w_start_ok || w_pass_end) r_passes <= w_passes_next;
            if (w_start_ok)  r_recs <= '0;
            else if (w_pop)  r_recs <= r_recs + 32'd1;
            if (w_start_ok)  r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
            if (w_issue && !w_ret)      r_outst <= r_outst + CW'(1);
            else if (!w_issue && w_ret) r_outst <= r_outst - CW'(1);
            if (w_push)                 r_wptr <= r_wptr + PW'(1);
            if (w_pop)                  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)       r_occ <= r_occ + CW'(1);
            else if (!w_push && w_pop)  r_occ <= r_occ - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= app_rd_data;
    end

    assign app_rd_cmd   = r_cmd;
    assign app_rd_addr  = r_addr;
    assign out_vld      = r_occ != '0;
    assign out_data     = (r_occ != '0) ? r_mem[r_rptr] : '0;
    assign busy         = r_state != IDLE;
    assign done         = r_state == DONE;
    assign cfg_err      = r_cfg_err;
    assign overflow     = r_ovf;
    assign passes_done  = r_passes;
    assign records_sent = r_recs;
endmodule

// File: tb/tb_dflow_replay_engine.sv
// tb/tb_dflow_replay_engine.sv - self-checking bench for dflow_replay_engine
module tb_dflow_replay_engine;
    localparam int AW = 19;
    localparam int DW = 144;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          resetn, cal_done, start_replay, stop_replay;
    logic [AW-1:0] addr_low, addr_high, app_rd_addr;
    logic [RW-1:0] replay_count, passes_done;
    logic          app_rd_cmd, app_rd_valid, out_vld, out_ready;
    logic [DW-1:0] app_rd_data, out_data;
    logic          busy, done, cfg_err, overflow;
    logic [31:0]   records_sent;

    int tests = 0;
    int fails = 0;
    int lat = 5;
    int rdy_mode = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [AW-1:0] iss_q[$];
    logic [DW-1:0] out_q[$];
    logic [AW-1:0] exp_q[$];
    typedef struct { int due; logic [AW-1:0] a; } ret_t;
    ret_t pq[$];

    dflow_replay_engine #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
                          .REPLAY_COUNT_WIDTH(RW), .RET_DEPTH(16)) dut (
        .clk(clk), .resetn(resetn), .cal_done(cal_done),
        .start_replay(start_replay), .stop_replay(stop_replay),
        .addr_low(addr_low), .addr_high(addr_high), .replay_count(replay_count),
        .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr),
        .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
        .out_data(out_data), .out_vld(out_vld), .out_ready(out_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err), .overflow(overflow),
        .passes_done(passes_done), .records_sent(records_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rec(input logic [AW-1:0] a);
        return {a, 17'h12345, ~a, 17'h0ABCD, a ^ 19'h5A5A5, 17'h1F0F0, a + 19'd7, 17'h00F0F};
    endfunction

    // QDR model: fixed latency, in-order returns
    initial begin
        ret_t e;
        app_rd_valid = 1'b0;
        app_rd_data  = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            app_rd_valid = 1'b0;
            if (app_rd_cmd) begin
                e.due = cyc + lat;
                e.a   = app_rd_addr;
                pq.push_back(e);
            end
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                app_rd_valid = 1'b1;
                app_rd_data  = rec(pq[0].a);
                void'(pq.pop_front());
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (app_rd_cmd) iss_q.push_back(app_rd_addr);
            if (out_vld && out_ready) out_q.push_back(out_data);
            if (done) done_cnt++;
        end
    end

    task automatic clear_mon();
        iss_q.delete();
        out_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input logic [RW-1:0] cnt);
        @(posedge clk); #2;
        clear_mon();
        addr_low = lo; addr_high = hi; replay_count = cnt;
        start_replay = 1'b1;
        @(posedge clk); #2;
        start_replay = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #2;
            if (done_cnt != 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({app_rd_cmd, app_rd_addr, out_vld, busy, done, cfg_err, overflow} !== '0) begin
            fails++; $display("FAIL reset_ctrl got %h want 0", {app_rd_cmd, app_rd_addr, out_vld, busy, done, cfg_err, overflow});
        end
        tests++;
        if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests++;
        if ({passes_done, records_sent} !== '0) begin
            fails++; $display("FAIL reset_counters got %h want 0", {passes_done, records_sent});
        end
    endtask

    task automatic test_basic();
        bit ok;
        lat = 5; rdy_mode = 0;
        exp_q.delete();
        for (int p = 0; p < 2; p++)
            for (int a = 'h10; a <= 'h13; a++) exp_q.push_back(AW'(a));
        do_start(19'h10, 19'h13, 32'd2);
        tests++;
        if ({app_rd_cmd, busy, app_rd_addr} !== {1'b1, 1'b1, 19'h10}) begin
            fails++; $display("FAIL basic_first_cmd got %h want %h", {app_rd_cmd, busy, app_rd_addr}, {1'b1, 1'b1, 19'h10});
        end
        wait_done(100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_done_timeout got 0 want 1"); end
        tests++;
        if (iss_q.size() !== 8) begin fails++; $display("FAIL basic_read_count got %0d want 8", iss_q.size()); end
        for (int i = 0; i < 8 && i < iss_q.size(); i++) begin
            tests++;
            if (iss_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_addr[%0d] got %h want %h", i, iss_q[i], exp_q[i]); end
        end
        tests++;
        if (out_q.size() !== 8) begin fails++; $display("FAIL basic_out_count got %0d want 8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== rec(exp_q[i])) begin fails++; $display("FAIL basic_out[%0d] got %h want %h", i, out_q[i], rec(exp_q[i])); end
        end
        tests++;
        if ({passes_done, records_sent} !== {32'd2, 32'd8}) begin
            fails++; $display("FAIL basic_counters got %h want %h", {passes_done, records_sent}, {32'd2, 32'd8});
        end
        tests++;
        if ({done_cnt[7:0], busy, overflow} !== {8'd1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL basic_end_state got %h want %h", {done_cnt[7:0], busy, overflow}, {8'd1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        lat = 3; rdy_mode = 1;
        do_start(19'h10, 19'h13, 32'd0);
        repeat (60) @(posedge clk);
        #2;
        tests++;
        if (iss_q.size() !== 16) begin fails++; $display("FAIL bp_credit_reads got %0d want 16", iss_q.size()); end
        tests++;
        if ({out_vld, app_rd_cmd, overflow} !== 3'b100) begin
            fails++; $display("FAIL bp_stall_state got %b want 100", {out_vld, app_rd_cmd, overflow});
        end
        rdy_mode = 2;
        repeat (80) @(posedge clk);
        #2;
        stop_replay = 1'b1;
        @(posedge clk); #2;
        stop_replay = 1'b0;
        tests++;
        if (app_rd_cmd !== 1'b0) begin fails++; $display("FAIL bp_stop_suppress got %b want 0", app_rd_cmd); end
        @(negedge clk);
        n = iss_q.size();
        wait_done(200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_done_timeout got 0 want 1"); end
        tests++;
        if (iss_q.size() !== n || out_q.size() !== n) begin
            fails++; $display("FAIL bp_no_loss got iss=%0d out=%0d want %0d", iss_q.size(), out_q.size(), n);
        end
        for (int i = 0; i < iss_q.size() && i < out_q.size(); i++) begin
            tests++;
            if (iss_q[i] !== AW'('h10 + i % 4) || out_q[i] !== rec(AW'('h10 + i % 4))) begin
                fails++; $display("FAIL bp_seq[%0d] got %h want %h", i, iss_q[i], AW'('h10 + i % 4));
            end
        end
        tests++;
        if (records_sent !== 32'(n)) begin fails++; $display("FAIL bp_records got %0d want %0d", records_sent, n); end
    endtask

    task automatic test_endless_stop();
        bit ok;
        int n;
        lat = $urandom_range(1, 8); rdy_mode = 2;
        do_start(19'h0, 19'h0, 32'd0);
        repeat (100) @(posedge clk);
        #2;
        stop_replay = 1'b1;
        @(posedge clk); #2;
        stop_replay = 1'b0;
        @(negedge clk);
        n = iss_q.size();
        wait_done(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL endless_done_timeout got 0 want 1"); end
        tests++;
        if (iss_q.size() !== n || n < 20) begin fails++; $display("FAIL endless_cmd_after_stop got %0d want %0d", iss_q.size(), n); end
        tests++;
        if (records_sent !== 32'(n) || out_q.size() !== n) begin
            fails++; $display("FAIL endless_records got %0d/%0d want %0d", records_sent, out_q.size(), n);
        end
        tests++;
        if (passes_done !== 32'(n)) begin fails++; $display("FAIL endless_passes got %0d want %0d", passes_done, n); end
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i] !== rec(19'h0) || iss_q[i] !== 19'h0) begin
                tests++; fails++;
                $display("FAIL endless_data[%0d] got %h want %h", i, out_q[i], rec(19'h0));
                break;
            end
        end
    endtask

    task automatic test_cfg_err();
        do_start(19'h20, 19'h1F, 32'd1);
        tests++;
        if ({cfg_err, busy, app_rd_cmd} !== 3'b100) begin
            fails++; $display("FAIL cfgerr_pulse got %b want 100", {cfg_err, busy, app_rd_cmd});
        end
        @(posedge clk); #2;
        tests++;
        if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfgerr_one_cycle got %b want 0", cfg_err); end
        repeat (10) @(posedge clk);
        #2;
        tests++;
        if (iss_q.size() !== 0 || busy !== 1'b0) begin
            fails++; $display("FAIL cfgerr_no_reads got %0d busy=%b want 0", iss_q.size(), busy);
        end
    endtask

    task automatic test_cal_done();
        cal_done = 1'b0;
        do_start(19'h10, 19'h13, 32'd1);
        tests++;
        if ({busy, app_rd_cmd, cfg_err} !== 3'b000) begin
            fails++; $display("FAIL caldone_ignored got %b want 000", {busy, app_rd_cmd, cfg_err});
        end
        repeat (8) @(posedge clk);
        #2;
        tests++;
        if (iss_q.size() !== 0) begin fails++; $display("FAIL caldone_no_reads got %0d want 0", iss_q.size()); end
        cal_done = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [AW-1:0] lo, hi;
        int cnt, sz;
        for (int it = 0; it < 5; it++) begin
            lo  = AW'($urandom_range(0, 300));
            sz  = $urandom_range(1, 6);
            hi  = lo + AW'(sz - 1);
            cnt = $urandom_range(1, 3);
            lat = $urandom_range(1, 8);
            rdy_mode = (it % 2 == 0) ? 2 : 0;
            exp_q.delete();
            for (int p = 0; p < cnt; p++)
                for (int k = 0; k < sz; k++) exp_q.push_back(lo + AW'(k));
            do_start(lo, hi, RW'(cnt));
            wait_done(200, ok);
            tests++;
            if (!ok || iss_q.size() !== exp_q.size() || out_q.size() !== exp_q.size()) begin
                fails++; $display("FAIL b2b%0d_sizes got %0d/%0d want %0d", it, iss_q.size(), out_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < iss_q.size() && i < out_q.size(); i++) begin
                tests++;
                if (iss_q[i] !== exp_q[i] || out_q[i] !== rec(exp_q[i])) begin
                    fails++; $display("FAIL b2b%0d_rec[%0d] got %h want %h", it, i, iss_q[i], exp_q[i]);
                end
            end
            tests++;
            if ({passes_done, records_sent, busy} !== {RW'(cnt), 32'(exp_q.size()), 1'b0}) begin
                fails++; $display("FAIL b2b%0d_counters got %0d/%0d want %0d/%0d", it, passes_done, records_sent, cnt, exp_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        lat = 12; rdy_mode = 1;
        do_start(19'h40, 19'h41, 32'd0);
        for (int i = 0; i < 20 && k < 5; i++) begin
            if (app_rd_cmd) k++;
            if (k < 5) begin @(posedge clk); #2; end
        end
        resetn = 1'b0;
        #1;
        tests++;
        if ({app_rd_cmd, app_rd_addr, out_vld, busy, done, cfg_err, overflow, passes_done, records_sent} !== '0) begin
            fails++; $display("FAIL rstmid_outputs got %h want 0",
                              {app_rd_cmd, app_rd_addr, out_vld, busy, done, cfg_err, overflow, passes_done, records_sent});
        end
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        repeat (25) @(posedge clk);
        #2;
        tests++;
        if ({overflow, out_vld, busy} !== 3'b000 || records_sent !== 0) begin
            fails++; $display("FAIL rstmid_stale_returns got %b rec=%0d want 000 rec=0", {overflow, out_vld, busy}, records_sent);
        end
        tests++;
        if (iss_q.size() !== 0 || done_cnt !== 0) begin
            fails++; $display("FAIL rstmid_quiet got iss=%0d done=%0d want 0/0", iss_q.size(), done_cnt);
        end
    endtask

    initial begin
        resetn = 1'b0; cal_done = 1'b1; start_replay = 1'b0; stop_replay = 1'b0;
        addr_low = '0; addr_high = '0; replay_count = '0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk); #2;
        test_reset();
        test_basic();
        test_backpressure();
        test_endless_stop();
        test_cfg_err();
        test_cal_done();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dflow_replay_engine.md
# dflow_replay_engine

Parametrised successor to the QDR-to-FIFO replay path of the dflow generator. Reads a stored tuple-record window [addr_low, addr_high] from QDR repeatedly (N passes or endless), and streams the records out over a valid/ready interface. Read requests are credit-limited by an internal return buffer, so read data can never overflow regardless of QDR read latency. Sits between the QDR user interface (qdr_clk domain) and outqueue.

## Interface
- MEM_ADDR_WIDTH, 19, QDR word address width
- MEM_DATA_WIDTH, 144, record width (QDR data width x burst length)
- REPLAY_COUNT_WIDTH, 32, width of pass count and pass counter
- RET_DEPTH, 16, return-buffer entries; power of two, >= 2

Ports:
- clk  in  1  QDR user clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- cal_done  in  1  QDR calibration complete
- start_replay  in  1  one-cycle start pulse
- stop_replay  in  1  one-cycle abort pulse
- addr_low  in  MEM_ADDR_WIDTH  first record address, latched at start
- addr_high  in  MEM_ADDR_WIDTH  last record address (inclusive), latched at start
- replay_count  in  REPLAY_COUNT_WIDTH  passes to run; 0 = endless
- app_rd_cmd  out  1  registered read strobe
- app_rd_addr  out  MEM_ADDR_WIDTH  registered read address
- app_rd_valid  in  1  read data valid; returns are in order, latency is arbitrary
- app_rd_data  in  MEM_DATA_WIDTH  read data
- out_data  out  MEM_DATA_WIDTH  record at head of the return buffer
- out_vld  out  1  return buffer not empty
- out_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on completion or abort
- cfg_err  out  1  one-cycle pulse when a start is rejected
- overflow  out  1  sticky; set if app_rd_valid arrives while the buffer is full
- passes_done  out  REPLAY_COUNT_WIDTH  passes completed; saturates at all-ones
- records_sent  out  32  out handshakes since start; wraps

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_replay with cal_done=1 and addr_high>=addr_low latches the config, sets cur=addr_low, clears passes_done, records_sent and overflow, and moves to ISSUE.
  - If addr_high<addr_low, cfg_err pulses and the FSM stays in IDLE.
  - start_replay with cal_done=0 is ignored.
- ISSUE:
  - Credit rule: a read issues when outstanding + occupancy < RET_DEPTH. Both terms are the registered values from the current cycle.
  - On issue: app_rd_cmd=1, app_rd_addr=cur.
  - If cur==addr_high, the pass ends: passes_done increments (saturating) and cur returns to addr_low. Otherwise cur increments.
  - If the pass ends and replay_count!=0 and the new passes_done==replay_count, the FSM moves to DRAIN.
  - stop_replay moves the FSM to DRAIN and suppresses any issue that cycle.
- DRAIN: no new reads issue. The FSM moves to DONE when outstanding==0 and the buffer is empty. In-flight reads are still accepted and delivered.
- DONE: done=1 for one cycle, then IDLE.
- Counters:
  - outstanding (log2(RET_DEPTH)+1 bits) increments on issue and decrements on app_rd_valid; a simultaneous issue and return leaves it unchanged.
  - passes_done and records_sent hold their values after done until the next accepted start.
- Return buffer is a first-word-fallthrough FIFO.
  - Push on app_rd_valid; pop on out_vld & out_ready.
  - Push and pop in the same cycle are both allowed, including when the buffer is full.
- Overflow: a push while full with no pop drops the data and sets overflow. This is only reachable through an interface protocol violation.
- start_replay while busy is ignored; stop_replay while IDLE is ignored.

## Timing
- Reset values (asynchronous): state=IDLE; app_rd_cmd=0; app_rd_addr=0; out_vld=0; out_data=0; busy, done, cfg_err and overflow = 0; all counters 0; buffer empty.
- Start accepted at cycle t -> busy=1 at t+1; first app_rd_cmd at t+1.
- Sustained issue rate is one read per cycle while credit is available.
- app_rd_valid at cycle t -> out_vld=1 and out_data valid at t+1, if the buffer was empty.
- A pop frees credit for an issue in the next cycle, not the same cycle.
- done pulses exactly one cycle after DRAIN's exit condition is met.
- resetn deasserted mid-operation aborts immediately. No done pulse; in-flight returns after release are dropped, because outstanding=0 after reset and overflow is not set.

## Test plan
- Window 0x10..0x13, replay_count=2, out_ready=1, read latency 5: reads 0x10,11,12,13,10,11,12,13; 8 records out in order; passes_done=2; done pulse; busy=0.
- Same window, out_ready=0, RET_DEPTH=16: exactly 16 reads issue, then app_rd_cmd stays 0; release out_ready and the stream resumes with no loss or duplication.
- replay_count=0, window 0x0..0x0: endless reads of addr 0. stop_replay after 100 cycles: no further cmd, all outstanding data delivered, then done; records_sent equals the reads issued.
- addr_low=0x20, addr_high=0x1F, start: cfg_err pulse, busy stays 0, no reads issue.
- start_replay with cal_done=0: ignored. Assert resetn=0 mid-ISSUE with 5 reads outstanding: all outputs return to reset values at once, and returns arriving afterwards do not set overflow.
